// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared types and constants for the PLL lock-acquisition sequencer
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FREQ_ACQ  = 3'd1,
        ST_PHASE_ACQ = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_FAULT     = 3'd4
    } lock_state_e;

    // EPU lock window select
    localparam logic [1:0] RANGE_WIDE   = 2'b11;
    localparam logic [1:0] RANGE_MID    = 2'b01;
    localparam logic [1:0] RANGE_NARROW = 2'b00;

    // Total kp/ki width from integer and fractional parts
    function automatic int k_width(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

endpackage

// File: rtl/lock_qualifier.sv
// rtl/lock_qualifier.sv - saturating dwell/unlock qualification of one EPU lock flag
module lock_qualifier #(
    parameter int CNT_W         = 16,
    parameter int DWELL_CYCLES  = 64,
    parameter int UNLOCK_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flag,
    input  logic clear,
    input  logic dwell_en,
    output logic qualified,
    output logic lost,
    output logic dwell_done
);

    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [CNT_W-1:0] dwell_cnt;
    logic [CNT_W-1:0] unlock_cnt;

    // Count consecutive high cycles (when enabled) and consecutive low cycles, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt  <= '0;
            unlock_cnt <= '0;
        end else begin
            if (clear || !flag || !dwell_en)
                dwell_cnt <= '0;
            else if (dwell_cnt != CNT_MAX)
                dwell_cnt <= dwell_cnt + 1'b1;

            if (clear || flag)
                unlock_cnt <= '0;
            else if (unlock_cnt != CNT_MAX)
                unlock_cnt <= unlock_cnt + 1'b1;
        end
    end

    // The current cycle completes the required run of high (or low) flag cycles
    assign qualified  = flag && (dwell_cnt >= DWELL_LAST);
    assign dwell_done = qualified && dwell_en;
    assign lost       = !flag && (unlock_cnt >= UNLOCK_LAST);

endmodule

// File: rtl/pll_lock_ctrl.sv
// rtl/pll_lock_ctrl.sv - PLL lock-acquisition sequencer; optional gain ramp under GAIN_RAMP_EN
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int K_INT_SIZE        = 8,
    parameter int K_FRAC_SIZE       = 8,
    parameter int CNT_W             = 16,
    parameter int DWELL_CYCLES      = 64,
    parameter int UNLOCK_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES    = 4096,
    parameter int RAMP_SHIFT_CYCLES = 16,
    localparam int K_W              = k_width(K_INT_SIZE, K_FRAC_SIZE)
) (
    input  logic                  clk_ref,
    input  logic                  rst,
    input  logic                  VDD,
    input  logic                  VSS,
    input  logic                  start,
    input  logic                  abort,
    input  logic signed [K_W-1:0] kp_acq,
    input  logic signed [K_W-1:0] ki_acq,
    input  logic signed [K_W-1:0] kp_trk,
    input  logic signed [K_W-1:0] ki_trk,
    input  logic                  freq_locked,
    input  logic                  phase_locked,
    output logic                  enable,
    output logic signed [K_W-1:0] kp,
    output logic signed [K_W-1:0] ki,
    output logic [1:0]            freq_lock_range,
    output logic [2:0]            state,
    output logic                  pll_locked,
    output logic                  lock_lost,
    output logic                  timeout_err
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    lock_state_e cur_state, next_state;
    logic        state_change, fallback, in_acq, timeout;
    logic        freq_qual, freq_lost, freq_done;
    logic        phase_qual, phase_lost, phase_done, phase_dwell_en;
    logic [CNT_W-1:0] tmo_cnt;

    logic                  enable_d, pll_locked_d, timeout_err_d, lock_lost_d;
    logic [1:0]            range_d;
    logic signed [K_W-1:0] kp_d, ki_d, ph_kp, ph_ki;

    // Supply pins pass through this block; qualified levels are informational only
    logic unused_sigs;
    assign unused_sigs = ^{VDD, VSS, freq_qual, phase_qual};

    assign state        = cur_state;
    assign state_change = (next_state != cur_state);
    assign in_acq       = (cur_state == ST_FREQ_ACQ) || (cur_state == ST_PHASE_ACQ);
    assign timeout      = in_acq && (tmo_cnt >= TMO_LAST);

    lock_qualifier #(
        .CNT_W(CNT_W), .DWELL_CYCLES(DWELL_CYCLES), .UNLOCK_CYCLES(UNLOCK_CYCLES)
    ) u_freq_qual (
        .clk(clk_ref), .rst(rst), .flag(freq_locked), .clear(state_change),
        .dwell_en(cur_state == ST_FREQ_ACQ),
        .qualified(freq_qual), .lost(freq_lost), .dwell_done(freq_done)
    );

    lock_qualifier #(
        .CNT_W(CNT_W), .DWELL_CYCLES(DWELL_CYCLES), .UNLOCK_CYCLES(UNLOCK_CYCLES)
    ) u_phase_qual (
        .clk(clk_ref), .rst(rst), .flag(phase_locked), .clear(state_change),
        .dwell_en(phase_dwell_en),
        .qualified(phase_qual), .lost(phase_lost), .dwell_done(phase_done)
    );

`ifdef GAIN_RAMP_EN
    localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_SHIFT_CYCLES - 1);

    logic [CNT_W-1:0]    ramp_cnt;
    logic                ramp_done, ramp_step, entering_phase;
    logic signed [K_W:0] kp_diff, ki_diff, kp_half, ki_half, kp_sum, ki_sum;
    logic signed [K_W-1:0] kp_stepped, ki_stepped;

    assign entering_phase = (next_state == ST_PHASE_ACQ) && (cur_state != ST_PHASE_ACQ);
    assign ramp_step      = (cur_state == ST_PHASE_ACQ) && !ramp_done && (ramp_cnt >= RAMP_LAST);
    assign phase_dwell_en = (cur_state == ST_PHASE_ACQ) && ramp_done;

    // Halve the remaining distance to the tracking gain; a zero half-step snaps exactly
    assign kp_diff    = $signed({kp_trk[K_W-1], kp_trk}) - $signed({kp[K_W-1], kp});
    assign ki_diff    = $signed({ki_trk[K_W-1], ki_trk}) - $signed({ki[K_W-1], ki});
    assign kp_half    = kp_diff >>> 1;
    assign ki_half    = ki_diff >>> 1;
    assign kp_sum     = $signed({kp[K_W-1], kp}) + kp_half;
    assign ki_sum     = $signed({ki[K_W-1], ki}) + ki_half;
    assign kp_stepped = (kp_half == '0) ? kp_trk : kp_sum[K_W-1:0];
    assign ki_stepped = (ki_half == '0) ? ki_trk : ki_sum[K_W-1:0];

    // Phase-acquisition gains: start at acq values, step periodically, then follow trk
    always_comb begin
        ph_kp = kp;
        ph_ki = ki;
        if (entering_phase) begin
            ph_kp = kp_acq;
            ph_ki = ki_acq;
        end else if (ramp_done) begin
            ph_kp = kp_trk;
            ph_ki = ki_trk;
        end else if (ramp_step) begin
            ph_kp = kp_stepped;
            ph_ki = ki_stepped;
        end
    end

    // Ramp pacing; any exit from PHASE_ACQ discards ramp progress
    always_ff @(posedge clk_ref) begin
        if (rst || state_change || cur_state != ST_PHASE_ACQ) begin
            ramp_cnt  <= '0;
            ramp_done <= 1'b0;
        end else if (!ramp_done) begin
            if (ramp_step) begin
                ramp_cnt  <= '0;
                ramp_done <= (kp_stepped == kp_trk) && (ki_stepped == ki_trk);
            end else begin
                ramp_cnt <= ramp_cnt + 1'b1;
            end
        end
    end
`else
    localparam int unused_ramp_cycles = RAMP_SHIFT_CYCLES;

    assign phase_dwell_en = (cur_state == ST_PHASE_ACQ);
    assign ph_kp          = kp_trk;
    assign ph_ki          = ki_trk;
`endif

    // Acquisition timeout counter, restarted on every state change
    always_ff @(posedge clk_ref) begin
        if (rst || state_change || !in_acq)
            tmo_cnt <= '0;
        else if (tmo_cnt != CNT_MAX)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // State and output registers; outputs are decodes of the next state
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            cur_state       <= ST_IDLE;
            enable          <= 1'b0;
            kp              <= '0;
            ki              <= '0;
            freq_lock_range <= RANGE_WIDE;
            pll_locked      <= 1'b0;
            lock_lost       <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            cur_state       <= next_state;
            enable          <= enable_d;
            kp              <= kp_d;
            ki              <= ki_d;
            freq_lock_range <= range_d;
            pll_locked      <= pll_locked_d;
            lock_lost       <= lock_lost_d;
            timeout_err     <= timeout_err_d;
        end
    end

    // Next state: abort > start > loss-of-lock > dwell advance > timeout
    always_comb begin
        next_state = cur_state;
        fallback   = 1'b0;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (cur_state)
                ST_IDLE, ST_FAULT: begin
                    if (start) next_state = ST_FREQ_ACQ;
                end
                ST_FREQ_ACQ: begin
                    if (freq_done)    next_state = ST_PHASE_ACQ;
                    else if (timeout) next_state = ST_FAULT;
                end
                ST_PHASE_ACQ: begin
                    if (freq_lost) begin
                        next_state = ST_FREQ_ACQ;
                        fallback   = 1'b1;
                    end else if (phase_done) begin
                        next_state = ST_LOCKED;
                    end else if (timeout) begin
                        next_state = ST_FAULT;
                    end
                end
                ST_LOCKED: begin
                    if (freq_lost) begin
                        next_state = ST_FREQ_ACQ;
                        fallback   = 1'b1;
                    end else if (phase_lost) begin
                        next_state = ST_PHASE_ACQ;
                        fallback   = 1'b1;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Output decode of the next state plus sticky lock_lost update
    always_comb begin
        enable_d      = 1'b0;
        kp_d          = '0;
        ki_d          = '0;
        range_d       = RANGE_WIDE;
        pll_locked_d  = 1'b0;
        timeout_err_d = 1'b0;
        case (next_state)
            ST_FREQ_ACQ: begin
                enable_d = 1'b1;
                kp_d     = kp_acq;
                ki_d     = ki_acq;
            end
            ST_PHASE_ACQ: begin
                enable_d = 1'b1;
                kp_d     = ph_kp;
                ki_d     = ph_ki;
                range_d  = RANGE_MID;
            end
            ST_LOCKED: begin
                enable_d     = 1'b1;
                kp_d         = kp_trk;
                ki_d         = ki_trk;
                range_d      = RANGE_NARROW;
                pll_locked_d = 1'b1;
            end
            ST_FAULT: timeout_err_d = 1'b1;
            default: ;
        endcase

        lock_lost_d = lock_lost;
        if (abort || (start && (cur_state == ST_IDLE || cur_state == ST_FAULT)))
            lock_lost_d = 1'b0;
        else if (fallback)
            lock_lost_d = 1'b1;
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb/tb_pll_lock_ctrl.sv - directed self-checking bench for pll_lock_ctrl
module tb_pll_lock_ctrl;

    localparam logic signed [15:0] KP_ACQ = 16'sh0400;
    localparam logic signed [15:0] KI_ACQ = 16'sh0100;
    localparam logic signed [15:0] KP_TRK = 16'sh0080;
    localparam logic signed [15:0] KI_TRK = 16'sh0010;

    logic clk_ref = 1'b0;
    logic rst, start, abort, freq_locked, phase_locked;
    logic signed [15:0] kp_acq, ki_acq, kp_trk, ki_trk, kp, ki;
    logic enable, pll_locked, lock_lost, timeout_err;
    logic [1:0] freq_lock_range;
    logic [2:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    pll_lock_ctrl dut (
        .clk_ref(clk_ref), .rst(rst), .VDD(1'b1), .VSS(1'b0),
        .start(start), .abort(abort),
        .kp_acq(kp_acq), .ki_acq(ki_acq), .kp_trk(kp_trk), .ki_trk(ki_trk),
        .freq_locked(freq_locked), .phase_locked(phase_locked),
        .enable(enable), .kp(kp), .ki(ki), .freq_lock_range(freq_lock_range),
        .state(state), .pll_locked(pll_locked), .lock_lost(lock_lost),
        .timeout_err(timeout_err)
    );

    always #5 clk_ref = ~clk_ref;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_ref);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        freq_locked = 1'b0; phase_locked = 1'b0;
        kp_acq = KP_ACQ; ki_acq = KI_ACQ; kp_trk = KP_TRK; ki_trk = KI_TRK;
        tick(2);
        rst = 1'b0;
        check("rst_state", 32'(state), 0);
        check("rst_enable", 32'(enable), 0);
        check("rst_range", 32'(freq_lock_range), 3);
        check("rst_kp", 32'(kp), 0);
        check("rst_flags", 32'({pll_locked, lock_lost, timeout_err}), 0);

        // Frequency acquisition
        start = 1'b1; tick(1); start = 1'b0;
        check("facq_state", 32'(state), 1);
        check("facq_enable", 32'(enable), 1);
        check("facq_kp", 32'(kp), 32'(KP_ACQ));
        check("facq_ki", 32'(ki), 32'(KI_ACQ));
        freq_locked = 1'b1;
        tick(63);
        check("facq_dwell63", 32'(state), 1);
        tick(1);
        check("pacq_state", 32'(state), 2);
        check("pacq_kp", 32'(kp), 32'(KP_TRK));
        check("pacq_ki", 32'(ki), 32'(KI_TRK));
        check("pacq_range", 32'(freq_lock_range), 1);

        // Phase acquisition to LOCKED
        phase_locked = 1'b1;
        tick(63);
        check("pacq_dwell63", 32'(state), 2);
        tick(1);
        check("lock_state", 32'(state), 3);
        check("lock_pll_locked", 32'(pll_locked), 1);
        check("lock_range", 32'(freq_lock_range), 0);
        start = 1'b1; tick(1); start = 1'b0;
        check("lock_start_ignored", 32'(state), 3);
        kp_trk = 16'sh00C0; tick(1);
        check("lock_gain_follow", 32'(kp), 32'h00C0);
        kp_trk = KP_TRK;

        // Short phase dropout tolerated, full one falls back
        phase_locked = 1'b0; tick(3); phase_locked = 1'b1; tick(1);
        check("drop3_stay", 32'(state), 3);
        check("drop3_lost", 32'(lock_lost), 0);
        phase_locked = 1'b0; tick(3);
        check("drop4_pre", 32'(state), 3);
        tick(1);
        check("drop4_state", 32'(state), 2);
        check("drop4_lost", 32'(lock_lost), 1);
        check("drop4_pll_locked", 32'(pll_locked), 0);
        phase_locked = 1'b1; tick(64);
        check("relock_state", 32'(state), 3);

        // Both flags lost together: frequency loss wins
        freq_locked = 1'b0; phase_locked = 1'b0; tick(4);
        check("both_state", 32'(state), 1);
        check("both_range", 32'(freq_lock_range), 3);
        check("both_kp", 32'(kp), 32'(KP_ACQ));

        // Abort, then timeout into FAULT
        abort = 1'b1; tick(1); abort = 1'b0;
        check("abort_state", 32'(state), 0);
        check("abort_lost", 32'(lock_lost), 0);
        start = 1'b1; tick(1); start = 1'b0;
        check("tmo_start", 32'(state), 1);
        tick(4095);
        check("tmo_pre", 32'(state), 1);
        tick(1);
        check("tmo_state", 32'(state), 4);
        check("tmo_err", 32'(timeout_err), 1);
        check("tmo_enable", 32'(enable), 0);
        check("tmo_kp", 32'(kp), 0);
        start = 1'b1; tick(1); start = 1'b0;
        check("fault_restart", 32'(state), 1);
        check("fault_err_clr", 32'(timeout_err), 0);

        // Abort coincident with dwell completion in PHASE_ACQ
        freq_locked = 1'b1; tick(64);
        check("ab_pacq", 32'(state), 2);
        freq_locked = 1'b0; tick(4);
        check("ab_fallback", 32'(state), 1);
        check("ab_lost_set", 32'(lock_lost), 1);
        freq_locked = 1'b1; tick(64);
        check("ab_pacq2", 32'(state), 2);
        phase_locked = 1'b1; tick(63);
        abort = 1'b1; tick(1); abort = 1'b0;
        check("ab_state", 32'(state), 0);
        check("ab_enable", 32'(enable), 0);
        check("ab_lost", 32'(lock_lost), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pll_lock_ctrl.md
Name: pll_lock_ctrl

Overview:
- Lock-acquisition sequencer for the PLL digital filter (EPU + loop filter + DS-DAC).
- Drives filter enable, kp/ki gain schedule and freq_lock_range from the EPU status flags freq_locked/phase_locked.
- Sequence: wide-gain frequency acquisition, then narrow-gain phase tracking, with loss-of-lock fallback and timeout fault.
- Sits beside the filter in the PLL top; all outputs are registered and connect directly to the filter's config inputs.

Parameters:
K_INT_SIZE, 8, integer bits of kp/ki
K_FRAC_SIZE, 8, fractional bits of kp/ki (K_W = K_INT_SIZE+K_FRAC_SIZE)
CNT_W, 16, width of the dwell and timeout counters
DWELL_CYCLES, 64, consecutive lock-flag cycles required to advance
UNLOCK_CYCLES, 4, consecutive deasserted-flag cycles that count as loss of lock
TIMEOUT_CYCLES, 4096, maximum cycles allowed in an acquisition state
RAMP_SHIFT_CYCLES, 16, cycles per gain ramp step (GAIN_RAMP_EN only)

Ports:
clk_ref  in  1  reference clock; the only clock
rst  in  1  synchronous, active-high reset
VDD  in  1  supply passthrough
VSS  in  1  supply passthrough
start  in  1  pulse: begin acquisition from IDLE or FAULT
abort  in  1  pulse: return to IDLE from any state
kp_acq, ki_acq  in  K_W each  signed acquisition gains
kp_trk, ki_trk  in  K_W each  signed tracking gains
freq_locked  in  1  EPU frequency-lock flag
phase_locked  in  1  EPU phase-lock flag
enable  out  1  filter enable
kp, ki  out  K_W each  signed gains to the loop filter
freq_lock_range  out  2  EPU lock window select
state  out  3  current FSM state
pll_locked  out  1  high in LOCKED
lock_lost  out  1  sticky; set on any fallback; cleared by start/abort/rst
timeout_err  out  1  high in FAULT

Behaviour:
- Reset (clk_ref edge with rst=1): state=IDLE, enable=0, kp=0, ki=0, freq_lock_range=2'b11, pll_locked=0, lock_lost=0, timeout_err=0, all counters=0.
- State encoding: IDLE=0, FREQ_ACQ=1, PHASE_ACQ=2, LOCKED=3, FAULT=4.
- Outputs are registered decodes of the next state, so they change on the same edge as state. Latency from a flag input to an output change is 1 cycle.
- Priority each cycle: rst > abort > start > loss-of-lock > dwell advance > timeout.
- abort from any state: go to IDLE and clear lock_lost.
- IDLE: enable=0, gains=0, range=2'b11.
  - start: go to FREQ_ACQ, clear lock_lost.
- FREQ_ACQ: enable=1, kp/ki=acq gains, range=2'b11.
  - dwell counter increments while freq_locked=1 and clears to 0 when it is 0.
  - dwell==DWELL_CYCLES-1 with freq_locked=1: go to PHASE_ACQ.
- PHASE_ACQ: enable=1, kp/ki=trk gains, range=2'b01.
  - Dwell counts on phase_locked; advance to LOCKED on the same rule as FREQ_ACQ.
  - freq_locked=0 for UNLOCK_CYCLES consecutive cycles: go to FREQ_ACQ and set lock_lost.
- LOCKED: enable=1, trk gains, range=2'b00, pll_locked=1. No timeout in this state.
  - freq_locked low for UNLOCK_CYCLES: go to FREQ_ACQ.
  - Otherwise phase_locked low for UNLOCK_CYCLES: go to PHASE_ACQ.
  - Frequency loss wins if both qualify on the same cycle. Either fallback sets lock_lost.
- Timeout: a counter increments every cycle in FREQ_ACQ/PHASE_ACQ.
  - Reaching TIMEOUT_CYCLES-1 without a transition: go to FAULT.
  - Dwell advance on that same cycle wins over timeout.
- FAULT: enable=0, gains=0, timeout_err=1.
  - start: go to FREQ_ACQ, clearing timeout_err and lock_lost.
  - abort: go to IDLE.
- Counter clearing:
  - Dwell, unlock and timeout counters all clear on every state change.
  - Unlock counters clear whenever the monitored flag is 1.
  - All counters saturate and never wrap.
- start while already in an acquisition state or LOCKED is ignored.
- Gain inputs are sampled every cycle. A change is visible on kp/ki one cycle later.

Optional Feature:
- Macro: GAIN_RAMP_EN.
- Without the macro: the FREQ_ACQ→PHASE_ACQ transition steps kp/ki to the trk gains in one cycle.
- With the macro:
  - On entry to PHASE_ACQ, kp/ki start at the acq values.
  - Every RAMP_SHIFT_CYCLES, each gain moves toward its trk value by arithmetic right shift of the difference by 1. The final step snaps exactly to trk.
  - Dwell counting in PHASE_ACQ starts only after the ramp completes. The timeout counter runs throughout.
  - A ramp interrupted by fallback or abort is discarded.

Decomposition:
- Package pll_ctrl_pkg:
  - lock_state_e enum (3-bit).
  - Range constants RANGE_WIDE=2'b11, RANGE_MID=2'b01, RANGE_NARROW=2'b00.
  - K_W localparam helper.
- Sub-module lock_qualifier: one instance per flag. It holds the saturating dwell/unlock counters and outputs qualified, lost and dwell_done. It is instantiated twice (freq, phase).

Test Plan:
- rst=1 for 2 cycles: state=0, enable=0, range=2'b11, all flags 0.
- start; freq_locked=1 from cycle 5, phase_locked=1 from cycle 80:
  - state=2 at cycle 5+64, then state=3 at cycle 80+64.
  - kp goes acq→trk at state 2 entry; pll_locked=1.
- In LOCKED, drop phase_locked for 3 cycles then restore: stay LOCKED. Drop it for 4 cycles: state=2 and lock_lost=1.
- In LOCKED, drop freq_locked and phase_locked together for 4 cycles: state=1 (freq priority), range=2'b11.
- start with freq_locked held 0: state=4 and timeout_err=1 after 4096 cycles. Then start: state=1, timeout_err=0.
- abort on the same cycle as a dwell completion in PHASE_ACQ: state=0, enable=0, lock_lost=0.
